pc_sequencer: RTL and testbench

// - Owns the program counter and sequences instruction fetch for the MCU core.
// - Drives the PC-source select (00 = PC+1, 01 = SR1OUT, 10 = PC-relative/hold), performs the PC update and runs the memory fetch handshake.
// - Hands each fetched instruction to execute, then waits for a redirect decision before the next fetch.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer: fetch, wait for memory, hand off to execute,
// apply the redirect. Optional PC-relative redirect enabled by defining PCSEQ_OFFSET_EN.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_rdata_i,
    output logic [15:0] ir_o,
    output logic        ir_valid_o,
    input  logic        exec_done_i,
    input  logic [1:0]  redirect_sel_i,
    input  logic [15:0] sr1_out_i,
    input  logic [8:0]  offset9_i,
    output logic [1:0]  pcmux_sel_o,
    output logic [15:0] pc_o,
    output logic        halted_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {StFetch, StWait, StExec, StHalt} state_e;

    localparam logic [7:0] WaitMaxC = 8'(WAIT_MAX);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [1:0]  pcmux_q, pcmux_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic [15:0] pc_rel;

`ifdef PCSEQ_OFFSET_EN
    assign pc_rel = pc_q + 16'd1 + {{7{offset9_i[8]}}, offset9_i};
`else
    logic unused_offset;
    assign unused_offset = ^offset9_i;
    // Without the offset path, select 10 refetches the current address.
    assign pc_rel = pc_q;
`endif

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        pcmux_d    = pcmux_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StFetch: begin
                mem_req_d = 1'b1;
                cnt_d     = 8'd0;
                state_d   = StWait;
            end
            StWait: begin
                // An ack on the final allowed wait cycle takes priority over the timeout.
                if (mem_ack_i) begin
                    ir_d       = mem_rdata_i;
                    ir_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = StExec;
                end else if (cnt_inc == WaitMaxC) begin
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StHalt;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StExec: begin
                if (exec_done_i) begin
                    pcmux_d = redirect_sel_i;
                    unique case (redirect_sel_i)
                        2'b00: begin
                            pc_d    = pc_q + 16'd1;
                            state_d = StFetch;
                        end
                        2'b01: begin
                            pc_d    = sr1_out_i;
                            state_d = StFetch;
                        end
                        2'b10: begin
                            pc_d    = pc_rel;
                            state_d = StFetch;
                        end
                        2'b11: begin
                            state_d = StHalt;
                        end
                    endcase
                end
            end
            StHalt: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            ir_q       <= 16'd0;
            ir_valid_q <= 1'b0;
            pcmux_q    <= 2'b00;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pcmux_q    <= pcmux_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = pc_q;
    assign ir_o        = ir_q;
    assign ir_valid_o  = ir_valid_q;
    assign pcmux_sel_o = pcmux_q;
    assign pc_o        = pc_q;
    assign halted_o    = (state_q == StHalt);
    assign fetch_err_o = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: acts as memory and execute unit, checks every fetch against
// a transaction-level model of PC flow and fetch timing.
module tb_pc_sequencer;

    localparam logic [15:0] ResetPc = 16'h3000;
    localparam int unsigned WaitMax = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [15:0] mem_rdata_i = 16'd0;
    logic [15:0] ir_o;
    logic        ir_valid_o;
    logic        exec_done_i = 1'b0;
    logic [1:0]  redirect_sel_i = 2'b00;
    logic [15:0] sr1_out_i = 16'd0;
    logic [8:0]  offset9_i = 9'd0;
    logic [1:0]  pcmux_sel_o;
    logic [15:0] pc_o;
    logic        halted_o;
    logic        fetch_err_o;

    pc_sequencer #(
        .RESET_PC (ResetPc),
        .WAIT_MAX (WaitMax)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .ir_o           (ir_o),
        .ir_valid_o     (ir_valid_o),
        .exec_done_i    (exec_done_i),
        .redirect_sel_i (redirect_sel_i),
        .sr1_out_i      (sr1_out_i),
        .offset9_i      (offset9_i),
        .pcmux_sel_o    (pcmux_sel_o),
        .pc_o           (pc_o),
        .halted_o       (halted_o),
        .fetch_err_o    (fetch_err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned model_pc;
    int unsigned last_req_cyc;
    int unsigned exp_period;
    bit          have_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Next PC from the redirect rules, plain modulo-2^16 arithmetic.
    function automatic int unsigned next_pc(input int unsigned pc, input logic [1:0] sel,
                                            input logic [15:0] sr1, input logic [8:0] off);
        int o;
        o = $signed(off);
        case (sel)
            2'b00:   return (pc + 1) % 65536;
            2'b01:   return int'(sr1);
`ifdef PCSEQ_OFFSET_EN
            2'b10:   return (int'(pc) + 1 + o) & 32'hFFFF;
`else
            2'b10:   return pc;
`endif
            default: return pc;
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("rst_pc", 32'(pc_o), 32'(ResetPc));
        check_eq("rst_mem_req", 32'(mem_req_o), 0);
        check_eq("rst_ir", 32'(ir_o), 0);
        check_eq("rst_ir_valid", 32'(ir_valid_o), 0);
        check_eq("rst_pcmux", 32'(pcmux_sel_o), 0);
        check_eq("rst_halted", 32'(halted_o), 0);
        check_eq("rst_fetch_err", 32'(fetch_err_o), 0);
        mem_ack_i   = 1'b0;
        exec_done_i = 1'b0;
        step();
        rst_ni    = 1'b1;
        model_pc  = ResetPc;
        have_last = 1'b0;
    endtask

    task automatic await_req();
        for (int i = 0; i < 4; i++) begin
            if (mem_req_o) break;
            step();
        end
        check_eq("req_seen", 32'(mem_req_o), 1);
    endtask

    task automatic do_fetch(input int ack_dly, input logic [15:0] data, input int exec_dly,
                            input logic [1:0] sel, input logic [15:0] sr1, input logic [8:0] off);
        await_req();
        if (have_last) check_eq("period", cyc - last_req_cyc, exp_period);
        last_req_cyc = cyc;
        have_last    = 1'b1;
        check_eq("mem_addr", 32'(mem_addr_o), model_pc);
        // exec_done with a halt select during the wait must be ignored.
        for (int i = 0; i < ack_dly; i++) begin
            exec_done_i    = 1'($urandom_range(0, 1));
            redirect_sel_i = 2'b11;
            step();
            check_eq("req_hold", 32'(mem_req_o), 1);
        end
        check_eq("no_err_wait", 32'(fetch_err_o), 0);
        exec_done_i = 1'b0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = data;
        step();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'($urandom);
        check_eq("ir_valid", 32'(ir_valid_o), 1);
        check_eq("ir", 32'(ir_o), 32'(data));
        check_eq("req_drop", 32'(mem_req_o), 0);
        for (int i = 0; i < exec_dly; i++) begin
            step();
            check_eq("ir_valid_pulse", 32'(ir_valid_o), 0);
        end
        exec_done_i    = 1'b1;
        redirect_sel_i = sel;
        sr1_out_i      = sr1;
        offset9_i      = off;
        step();
        exec_done_i    = 1'b0;
        redirect_sel_i = 2'($urandom);
        sr1_out_i      = 16'($urandom);
        model_pc       = next_pc(model_pc, sel, sr1, off);
        check_eq("pc", 32'(pc_o), model_pc);
        check_eq("pcmux_sel", 32'(pcmux_sel_o), 32'(sel));
        check_eq("halted", 32'(halted_o), (sel == 2'b11) ? 1 : 0);
        exp_period = ack_dly + exec_dly + 3;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Sequential fetches from the reset PC.
        for (int i = 0; i < 3; i++) do_fetch(0, 16'($urandom), 0, 2'b00, 16'd0, 9'd0);
        // Wrap at the top of the address space.
        do_fetch(1, 16'h1111, 0, 2'b01, 16'hFFFF, 9'd0);
        do_fetch(0, 16'h2222, 1, 2'b00, 16'd0, 9'd0);
        check_eq("wrap_pc", 32'(pc_o), 0);
        do_fetch(0, 16'h3333, 0, 2'b01, 16'h4120, 9'd0);
        do_fetch(2, 16'h4444, 0, 2'b01, 16'h3005, 9'd0);
        do_fetch(0, 16'h5555, 0, 2'b10, 16'd0, 9'h1FE);
        do_fetch(WaitMax - 1, 16'h6666, 0, 2'b00, 16'd0, 9'd0);
        check_eq("late_ack_no_err", 32'(fetch_err_o), 0);
        for (int n = 0; n < 50; n++) begin
            do_fetch(int'($urandom_range(0, WaitMax - 1)), 16'($urandom),
                     int'($urandom_range(0, 4)), 2'($urandom_range(0, 2)),
                     16'($urandom), 9'($urandom));
        end
        do_fetch(0, 16'h7777, 0, 2'b11, 16'h1234, 9'd0);
        // HALT ignores memory and execute activity.
        exec_done_i    = 1'b1;
        redirect_sel_i = 2'b00;
        mem_ack_i      = 1'b1;
        for (int i = 0; i < 3; i++) step();
        exec_done_i = 1'b0;
        mem_ack_i   = 1'b0;
        check_eq("halt_pc", 32'(pc_o), model_pc);
        check_eq("halt_req", 32'(mem_req_o), 0);
        check_eq("halt_stays", 32'(halted_o), 1);
        check_eq("halt_no_err", 32'(fetch_err_o), 0);

        // Fetch timeout.
        do_reset();
        await_req();
        for (int i = 0; i < WaitMax - 1; i++) step();
        check_eq("to_req_before", 32'(mem_req_o), 1);
        check_eq("to_err_before", 32'(fetch_err_o), 0);
        step();
        check_eq("to_err", 32'(fetch_err_o), 1);
        check_eq("to_halted", 32'(halted_o), 1);
        check_eq("to_req", 32'(mem_req_o), 0);
        mem_ack_i = 1'b1;
        step();
        step();
        mem_ack_i = 1'b0;
        check_eq("to_err_sticky", 32'(fetch_err_o), 1);
        check_eq("to_ir", 32'(ir_o), 0);

        // Reset during an outstanding request; a late ack is dropped.
        do_reset();
        do_fetch(0, 16'hABCD, 0, 2'b00, 16'd0, 9'd0);
        await_req();
        rst_ni = 1'b0;
        #1;
        check_eq("midrst_req", 32'(mem_req_o), 0);
        check_eq("midrst_ir", 32'(ir_o), 0);
        #2;
        rst_ni      = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'hBEEF;
        step();
        mem_ack_i = 1'b0;
        check_eq("late_ack_ir", 32'(ir_o), 0);
        check_eq("late_ack_valid", 32'(ir_valid_o), 0);
        check_eq("late_ack_req", 32'(mem_req_o), 1);
        model_pc  = ResetPc;
        have_last = 1'b0;
        do_fetch(1, 16'hC0DE, 0, 2'b00, 16'd0, 9'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
